grey_ring_div: RTL and testbench

Parametrised ring-code counter and clock divider. Successor to the fixed 5-bit decade grey counter. Generalised to W state bits and modulus 2·W, with:
- count enable, up/down direction and synchronous clear;
- wrap (terminal-count) flag and a decoded binary index;
- a 50 % divided clock, and optional illegal-code detection.

It sits beside the ring-oscillator/counter chains and supplies glitch-safe count codes and divided clocks to downstream logic.

---
 rtl/grey_ring_div.sv | 107 ++++++++++
 tb/tb_grey_ring_div.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/grey_ring_div.sv
// rtl/grey_ring_div.sv - W-bit ring-code up/down counter with 50% divided clock and wrap flag
// Optional sticky illegal-code flag o_err is built only when GREY_RING_CHECK_EN is defined.
module grey_ring_div #(
  parameter int W = 5,
  localparam int M = 2 * W,
  localparam int IW = $clog2(2 * W)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_dir,
  input  logic          i_clr,
  output logic [W-1:0]  o_cnt,
  output logic [IW-1:0] o_idx,
  output logic          o_clk_div,
  output logic          o_tc,
  output logic          o_err
);

  // Index n: bit n/2 set, plus the bit below it (cyclically) for even n.
  function automatic logic [W-1:0] f_code(input int n);
    logic [W-1:0] c;
    int           k;
    k = n / 2;
    c = {{(W-1){1'b0}}, 1'b1} << k;
    if ((n % 2) == 0) c = c | ({{(W-1){1'b0}}, 1'b1} << ((k + W - 1) % W));
    return c;
  endfunction

  localparam logic [W-1:0] CODE0 = f_code(0);

  logic [W-1:0]  r_cnt;
  logic          r_clk_div;
  logic          r_tc;
  logic [IW-1:0] w_idx;
  logic          w_legal;
  logic [IW-1:0] w_idx_up;
  logic [IW-1:0] w_idx_dn;
  logic [IW-1:0] w_nidx;
  logic [W-1:0]  w_ncode;
  logic          w_nclk;
  logic          w_ntc;

  always_comb begin
    w_idx   = '0;
    w_legal = 1'b0;
    for (int n = 0; n < M; n++) begin
      if (r_cnt == f_code(n)) begin
        w_idx   = IW'(n);
        w_legal = 1'b1;
      end
    end
  end

  assign w_idx_up = (w_idx == IW'(M - 1)) ? '0 : w_idx + 1'b1;
  assign w_idx_dn = (w_idx == '0) ? IW'(M - 1) : w_idx - 1'b1;

  always_comb begin
    w_nidx = w_idx;
    if (i_clr || !w_legal) w_nidx = '0;
    else if (i_en)         w_nidx = i_dir ? w_idx_up : w_idx_dn;
  end

  always_comb begin
    w_ncode = CODE0;
    for (int n = 0; n < M; n++) begin
      if (w_nidx == IW'(n)) w_ncode = f_code(n);
    end
  end

  // Divided clock is derived from the next index so it always matches the code it ships with.
  assign w_nclk = (w_nidx >= IW'(W));
  assign w_ntc  = !i_clr && w_legal && i_en &&
                  (i_dir ? (w_idx == IW'(M - 1)) : (w_idx == '0));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= CODE0;
      r_clk_div <= 1'b0;
      r_tc      <= 1'b0;
    end else begin
      r_cnt     <= w_ncode;
      r_clk_div <= w_nclk;
      r_tc      <= w_ntc;
    end
  end

`ifdef GREY_RING_CHECK_EN
  logic r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_err <= 1'b0;
    else if (i_clr)    r_err <= 1'b0;
    else if (!w_legal) r_err <= 1'b1;
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_cnt     = r_cnt;
  assign o_idx     = w_idx;
  assign o_clk_div = r_clk_div;
  assign o_tc      = r_tc;

endmodule

// File: tb/tb_grey_ring_div.sv
// tb/tb_grey_ring_div.sv - directed self-checking bench for grey_ring_div (W=5 and W=7 instances)
module tb_grey_ring_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en5, dir5, clr5;
  logic [4:0] cnt5;
  logic [3:0] idx5;
  logic       div5, tc5, err5;
  logic       en7, dir7, clr7;
  logic [6:0] cnt7;
  logic [3:0] idx7;
  logic       div7, tc7, err7;

  grey_ring_div #(.W(5)) u5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en5), .i_dir(dir5), .i_clr(clr5),
    .o_cnt(cnt5), .o_idx(idx5), .o_clk_div(div5), .o_tc(tc5), .o_err(err5)
  );

  grey_ring_div #(.W(7)) u7 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en7), .i_dir(dir7), .i_clr(clr7),
    .o_cnt(cnt7), .o_idx(idx7), .o_clk_div(div7), .o_tc(tc7), .o_err(err7)
  );

`ifdef GREY_RING_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic [4:0] cw5 [10] = '{5'b10001, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                           5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};
  logic [6:0] cw7 [14] = '{7'b1000001, 7'b0000001, 7'b0000011, 7'b0000010,
                           7'b0000110, 7'b0000100, 7'b0001100, 7'b0001000,
                           7'b0011000, 7'b0010000, 7'b0110000, 7'b0100000,
                           7'b1100000, 7'b1000000};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int midx;
    logic e;
    logic ntc;

    rst_n = 1'b0;
    en5 = 1'b0; dir5 = 1'b1; clr5 = 1'b0;
    en7 = 1'b0; dir7 = 1'b0; clr7 = 1'b0;
    #12;
    check("rst_cnt5", 32'(cnt5), 32'(5'b10001));
    check("rst_idx5", 32'(idx5), 32'd0);
    check("rst_div5", 32'(div5), 32'd0);
    check("rst_tc5",  32'(tc5),  32'd0);
    check("rst_err5", 32'(err5), 32'd0);
    check("rst_cnt7", 32'(cnt7), 32'(7'b1000001));
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 1; c <= 20; c++) begin
      en5 = 1'b1; dir5 = 1'b1;
      tick();
      check("up_cnt", 32'(cnt5), 32'(cw5[c % 10]));
      check("up_idx", 32'(idx5), 32'(c % 10));
      check("up_div", 32'(div5), 32'((c % 10) >= 5));
      check("up_tc",  32'(tc5),  32'((c % 10) == 0));
    end

    for (int c = 0; c < 6; c++) tick();
    check("pre_rst_div", 32'(div5), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(cnt5), 32'(5'b10001));
    check("async_rst_idx", 32'(idx5), 32'd0);
    check("async_rst_div", 32'(div5), 32'd0);
    check("async_rst_tc",  32'(tc5),  32'd0);
    check("async_rst_err", 32'(err5), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    midx = 0;
    for (int i = 0; i < 40; i++) begin
      e = ((i % 2) == 0);
      en5 = e; dir5 = 1'b1;
      tick();
      ntc = e && (midx == 9);
      if (e) midx = (midx + 1) % 10;
      check("gap_cnt", 32'(cnt5), 32'(cw5[midx]));
      check("gap_div", 32'(div5), 32'(midx >= 5));
      check("gap_tc",  32'(tc5),  32'(ntc));
    end

    en5 = 1'b1; dir5 = 1'b1;
    tick(); tick(); tick();
    check("flip_at3", 32'(idx5), 32'd3);
    dir5 = 1'b0;
    tick();
    check("flip_idx", 32'(idx5), 32'd2);
    check("flip_cnt", 32'(cnt5), 32'(5'b00011));
    check("flip_tc",  32'(tc5),  32'd0);

    dir5 = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("clr_at7",  32'(idx5), 32'd7);
    check("clr_div7", 32'(div5), 32'd1);
    clr5 = 1'b1;
    tick();
    check("clr_cnt", 32'(cnt5), 32'(5'b10001));
    check("clr_idx", 32'(idx5), 32'd0);
    check("clr_div", 32'(div5), 32'd0);
    check("clr_tc",  32'(tc5),  32'd0);
    clr5 = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    check("clr9_at9", 32'(idx5), 32'd9);
    clr5 = 1'b1;
    tick();
    check("clr9_tc",  32'(tc5),  32'd0);
    check("clr9_cnt", 32'(cnt5), 32'(5'b10001));
    clr5 = 1'b0; en5 = 1'b0;

    for (int c = 1; c <= 14; c++) begin
      en7 = 1'b1; dir7 = 1'b0;
      tick();
      check("dn7_idx", 32'(idx7), 32'((14 - c) % 14));
      check("dn7_cnt", 32'(cnt7), 32'(cw7[(14 - c) % 14]));
      check("dn7_div", 32'(div7), 32'(((14 - c) % 14) >= 7));
      check("dn7_tc",  32'(tc7),  32'(c == 1));
    end
    en7 = 1'b0;

    @(negedge clk);
    en5 = 1'b0; clr5 = 1'b0;
    force u5.r_cnt = 5'b11111;
    #1;
    check("ill_idx", 32'(idx5), 32'd0);
    @(negedge clk);
    release u5.r_cnt;
    tick();
    check("ill_cnt", 32'(cnt5), 32'(5'b10001));
    check("ill_idx0", 32'(idx5), 32'd0);
    check("ill_err", 32'(err5), 32'(ERR_EXP));
    tick();
    check("ill_err_sticky", 32'(err5), 32'(ERR_EXP));
    clr5 = 1'b1;
    tick();
    check("ill_err_clr", 32'(err5), 32'd0);
    check("ill_cnt_clr", 32'(cnt5), 32'(5'b10001));

    @(negedge clk);
    clr5 = 1'b1;
    force u5.r_cnt = 5'b11111;
    @(negedge clk);
    release u5.r_cnt;
    tick();
    check("illclr_err", 32'(err5), 32'd0);
    check("illclr_cnt", 32'(cnt5), 32'(5'b10001));
    clr5 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
